// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg: shared pipeline-stage types, NOP constant, bubble helper |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rd_wren;
    } stage_hdr_t;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } id_ex_payload_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] st_data;
        logic [1:0]  wb_sel;
        logic [29:0] rsvd;
    } ex_mem_payload_t;

    function automatic logic [31:0] bubble_instr(input logic        valid,
                                                 input logic [31:0] instr,
                                                 input logic [31:0] nop);
        return valid ? instr : nop;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_slot: one pipeline storage entry with valid bit               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_slot #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_o <= 1'b0;
            q_o     <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            q_o     <= d_i;
        end else if (clear_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage_reg: valid/ready pipeline register, optional skid entry |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          DATA_W    = 96,
    parameter int          SKID      = 1,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       pc_i,
    input  logic              rd_wren_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic              rd_wren_o,
    output logic [DATA_W-1:0] data_o
);

    typedef struct packed {
        stage_hdr_t          hdr;
        logic [DATA_W-1:0]   data;
    } entry_t;

    localparam int ENT_W = $bits(entry_t);

    entry_t in_ent;
    entry_t m_d;
    entry_t m_q;
    logic   m_valid;
    logic   m_load;
    logic   m_clear;
    logic   accept;
    logic   issue;

    assign in_ent.hdr.instr   = instr_i;
    assign in_ent.hdr.pc      = pc_i;
    assign in_ent.hdr.rd_wren = rd_wren_i;
    assign in_ent.data        = data_i;

    assign accept = valid_i & ready_o;
    assign issue  = m_valid & ready_i;

    pipe_slot #(.W(ENT_W)) u_main (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .flush_i  (flush_i),
        .load_i   (m_load),
        .clear_i  (m_clear),
        .d_i      (m_d),
        .valid_o  (m_valid),
        .q_o      (m_q)
    );

    generate
        if (SKID == 0) begin : g_single
            assign ready_o = ready_i | ~m_valid;
            assign m_load  = accept;
            assign m_clear = issue;
            assign m_d     = in_ent;
        end else begin : g_skid
            logic   s_valid;
            entry_t s_q;
            logic   s_load;
            logic   s_clear;

            // Registered ready: only the skid occupancy gates upstream.
            assign ready_o = ~s_valid;
            // Refill main from skid first; a new accept can only target main
            // when skid is empty (ready_o guarantees that).
            assign m_load  = (issue & s_valid) | (accept & (~m_valid | issue));
            assign m_clear = issue & ~m_load;
            assign m_d     = s_valid ? s_q : in_ent;
            assign s_load  = accept & m_valid & ~issue;
            assign s_clear = issue & s_valid;

            pipe_slot #(.W(ENT_W)) u_skid (
                .clk_i    (clk_i),
                .reset_ni (reset_ni),
                .flush_i  (flush_i),
                .load_i   (s_load),
                .clear_i  (s_clear),
                .d_i      (in_ent),
                .valid_o  (s_valid),
                .q_o      (s_q)
            );
        end
    endgenerate

    assign valid_o   = m_valid;
    assign instr_o   = bubble_instr(m_valid, m_q.hdr.instr, NOP_INSTR);
    assign rd_wren_o = m_valid & m_q.hdr.rd_wren;
    assign pc_o      = m_q.hdr.pc;
    assign data_o    = m_q.data;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_stage_reg: dut0 SKID=0/DATA_W=96, dut1 SKID=1/DATA_W=8      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rd;
        logic [95:0] data;
    } ent_t;

    typedef struct {
        logic        v;
        logic        r;
        logic        f;
        logic [31:0] instr;
        logic        exp_vo;
        logic        exp_ro;
        logic [31:0] exp_io;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i   [2];
    logic        valid_i   [2];
    logic        ready_i   [2];
    logic        rd_wren_i [2];
    logic [31:0] instr_i   [2];
    logic [31:0] pc_i      [2];
    logic        ready_o   [2];
    logic        valid_o   [2];
    logic        rd_wren_o [2];
    logic [31:0] instr_o   [2];
    logic [31:0] pc_o      [2];
    logic [95:0] data_i0, data_o0;
    logic [7:0]  data_i1, data_o1;

    int   checks = 0;
    int   errors = 0;
    ent_t sb0[$];
    ent_t sb1[$];
    ent_t offer[2];
    bit   hold[2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .SKID(0), .NOP_INSTR(NOP)) dut0 (
        .clk_i(clk), .reset_ni(rst_n), .flush_i(flush_i[0]), .valid_i(valid_i[0]),
        .ready_o(ready_o[0]), .instr_i(instr_i[0]), .pc_i(pc_i[0]), .rd_wren_i(rd_wren_i[0]),
        .data_i(data_i0), .valid_o(valid_o[0]), .ready_i(ready_i[0]), .instr_o(instr_o[0]),
        .pc_o(pc_o[0]), .rd_wren_o(rd_wren_o[0]), .data_o(data_o0)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID(1), .NOP_INSTR(NOP)) dut1 (
        .clk_i(clk), .reset_ni(rst_n), .flush_i(flush_i[1]), .valid_i(valid_i[1]),
        .ready_o(ready_o[1]), .instr_i(instr_i[1]), .pc_i(pc_i[1]), .rd_wren_i(rd_wren_i[1]),
        .data_i(data_i1), .valid_o(valid_o[1]), .ready_i(ready_i[1]), .instr_o(instr_o[1]),
        .pc_o(pc_o[1]), .rd_wren_o(rd_wren_o[1]), .data_o(data_o1)
    );

    task automatic chk(input string name, input int k, input logic [160:0] act,
                       input logic [160:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic qpush(input int k, input ent_t e);
        if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    endtask

    task automatic qpop(input int k, output ent_t e);
        if (k == 0) e = sb0.pop_front(); else e = sb1.pop_front();
    endtask

    task automatic qclear(input int k);
        if (k == 0) sb0.delete(); else sb1.delete();
    endtask

    function automatic ent_t mk(input int k, input logic [31:0] instr, input logic [31:0] pc,
                                input logic rd, input logic [95:0] data);
        ent_t e;
        e.instr = instr;
        e.pc    = pc;
        e.rd    = rd;
        e.data  = (k == 1) ? {88'd0, data[7:0]} : data;
        return e;
    endfunction

    task automatic apply(input int k);
        instr_i[k]   = offer[k].instr;
        pc_i[k]      = offer[k].pc;
        rd_wren_i[k] = offer[k].rd;
        if (k == 0) data_i0 = offer[k].data;
        else        data_i1 = offer[k].data[7:0];
    endtask

    // Called with inputs settled (#1 after driving); checks, scores, then advances one cycle.
    task automatic eval_cycle();
        for (int k = 0; k < 2; k++) begin
            int   n;
            bit   acc;
            bit   iss;
            logic exp_ro;
            ent_t e;
            n      = qsize(k);
            acc    = valid_i[k] && ready_o[k];
            iss    = valid_o[k] && ready_i[k];
            exp_ro = (k == 1) ? (n < 2) : (ready_i[k] || n == 0);
            chk("valid_o", k, valid_o[k], n != 0);
            chk("ready_o", k, ready_o[k], exp_ro);
            if (!valid_o[k]) begin
                chk("bubble_instr", k, instr_o[k], NOP);
                chk("bubble_rd_wren", k, rd_wren_o[k], 1'b0);
            end
            if (flush_i[k]) begin
                qclear(k);
                hold[k] = 1'b0;
            end else begin
                if (iss) begin
                    if (n == 0) begin
                        chk("issue_nonempty", k, 0, 1);
                    end else begin
                        qpop(k, e);
                        chk("instr_o", k, instr_o[k], e.instr);
                        chk("pc_o", k, pc_o[k], e.pc);
                        chk("rd_wren_o", k, rd_wren_o[k], e.rd);
                        if (k == 0) chk("data_o", k, data_o0, e.data);
                        else        chk("data_o", k, data_o1, e.data[7:0]);
                    end
                end
                if (acc) qpush(k, offer[k]);
                hold[k] = valid_i[k] && !acc;
            end
        end
        begin
            logic saved;
            saved      = ready_o[1];
            ready_i[1] = !ready_i[1];
            #1;
            chk("ready_indep", 1, ready_o[1], saved);
            ready_i[1] = !ready_i[1];
            #1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_check();
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid_o", k, valid_o[k], 1'b0);
            chk("rst_ready_o", k, ready_o[k], 1'b1);
            chk("rst_instr_o", k, instr_o[k], NOP);
            chk("rst_rd_wren_o", k, rd_wren_o[k], 1'b0);
            chk("rst_pc_o", k, pc_o[k], 32'd0);
            qclear(k);
            hold[k] = 1'b0;
        end
        chk("rst_data_o", 0, data_o0, 96'd0);
        chk("rst_data_o", 1, data_o1, 8'd0);
    endtask

    initial begin
        vec_t tbl[11];
        logic [31:0] A;
        A = 32'h00A0_0093;
        tbl[0]  = '{1, 1, 0, A,      0, 1, NOP};
        tbl[1]  = '{1, 0, 0, A + 4,  1, 1, A};
        tbl[2]  = '{1, 0, 0, A + 8,  1, 0, A};
        tbl[3]  = '{1, 0, 0, A + 8,  1, 0, A};
        tbl[4]  = '{1, 1, 0, A + 8,  1, 0, A};
        tbl[5]  = '{1, 1, 0, A + 8,  1, 1, A + 4};
        tbl[6]  = '{1, 0, 0, A + 12, 1, 1, A + 8};
        tbl[7]  = '{1, 0, 1, A + 16, 1, 0, A + 8};
        tbl[8]  = '{0, 1, 0, A + 16, 0, 1, NOP};
        tbl[9]  = '{1, 1, 1, A + 16, 0, 1, NOP};
        tbl[10] = '{0, 1, 0, A + 16, 0, 1, NOP};

        for (int k = 0; k < 2; k++) begin
            flush_i[k] = 0; valid_i[k] = 0; ready_i[k] = 0;
            offer[k] = mk(k, 32'h1111_1111, 32'h2222_2222, 1'b1, {3{32'h3333_3333}});
            apply(k);
        end
        #2;
        reset_check();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream, both variants
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 2; k++) begin
                valid_i[k] = (i < 8);
                ready_i[k] = 1'b1;
                offer[k]   = mk(k, A + 32'(4 * i), 32'h1000 + 32'(4 * i), i[0],
                                {$urandom, $urandom, $urandom});
                apply(k);
            end
            #1;
            eval_cycle();
        end

        // Stall / skid / flush sequence on the SKID=1 instance
        valid_i[0] = 1'b0;
        ready_i[0] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            valid_i[1] = tbl[i].v;
            ready_i[1] = tbl[i].r;
            flush_i[1] = tbl[i].f;
            offer[1]   = mk(1, tbl[i].instr, 32'h2000 + tbl[i].instr, 1'b1, {88'd0, tbl[i].instr[7:0]});
            apply(1);
            #1;
            chk("tbl_valid_o", i, valid_o[1], tbl[i].exp_vo);
            chk("tbl_ready_o", i, ready_o[1], tbl[i].exp_ro);
            chk("tbl_instr_o", i, instr_o[1], tbl[i].exp_io);
            eval_cycle();
        end
        flush_i[1] = 1'b0;

        // Fill both, then reset asynchronously mid-cycle
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                valid_i[k] = 1'b1;
                ready_i[k] = 1'b0;
                offer[k]   = mk(k, A + 32'(64 + 4 * i), 32'h3000, 1'b1, {3{$urandom}});
                apply(k);
            end
            #1;
            eval_cycle();
        end
        valid_i[0] = 1'b0;
        valid_i[1] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        reset_check();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 2; k++) begin
                flush_i[k] = ($urandom_range(0, 24) == 0);
                ready_i[k] = ($urandom_range(0, 3) != 0);
                if (!hold[k]) begin
                    valid_i[k] = ($urandom_range(0, 2) != 0);
                    offer[k]   = mk(k, $urandom, $urandom, 1'($urandom),
                                    {$urandom, $urandom, $urandom});
                end
                apply(k);
            end
            #1;
            eval_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
